// File: rtl/regfile_port_ctrl.sv
// Port controller for a 16x16 register file: power-on/requested clear sequence,
// write-port arbitration between writeback and debug, and write-before-read bypass.
module regfile_port_ctrl #(
  parameter int NREG   = 16,
  parameter int AW     = 4,
  parameter int DW     = 16,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic          wb_stall,
  input  logic          dbg_wr_valid,
  output logic          dbg_wr_ready,
  input  logic [AW-1:0] dbg_wr_reg,
  input  logic [DW-1:0] dbg_wr_data,
  input  logic          clear_req,
  input  logic [AW-1:0] rd_reg1,
  input  logic [AW-1:0] rd_reg2,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_wr_reg,
  output logic [DW-1:0] rf_wr_data,
  output logic          rf_rd_en1,
  output logic          rf_rd_en2,
  output logic [AW-1:0] rf_rd_reg1,
  output logic [AW-1:0] rf_rd_reg2,
  input  logic [DW-1:0] rf_rd_data1,
  input  logic [DW-1:0] rf_rd_data2,
  output logic          init_done
);

  localparam int SW = $clog2(STARVE + 1);

  typedef enum logic {INIT, ACTIVE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt, clr_cnt_nxt;
  logic [SW-1:0]   starve_cnt, starve_nxt;
  logic            force_dbg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT;
      clr_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_cnt_nxt  = clr_cnt;
    starve_nxt   = starve_cnt;
    force_dbg    = 1'b0;
    rf_wr_en     = 1'b0;
    rf_wr_reg    = '0;
    rf_wr_data   = '0;
    rf_rd_en1    = 1'b0;
    rf_rd_en2    = 1'b0;
    dbg_wr_ready = 1'b0;
    wb_stall     = 1'b1;
    init_done    = 1'b0;
    // Outputs are gated by rst so the array sees no write while reset is held.
    if (rst) begin
      case (state)
        INIT: begin
          rf_wr_en    = 1'b1;
          rf_wr_reg   = clr_cnt;
          clr_cnt_nxt = clr_cnt + 1'b1;
          if (clr_cnt == AW'(NREG - 1)) begin
            state_nxt   = ACTIVE;
            clr_cnt_nxt = '0;
          end
        end
        ACTIVE: begin
          init_done = 1'b1;
          rf_rd_en1 = 1'b1;
          rf_rd_en2 = 1'b1;
          wb_stall  = 1'b0;
          force_dbg = dbg_wr_valid && (starve_cnt == SW'(STARVE));
          if (wb_valid && !force_dbg) begin
            rf_wr_en   = 1'b1;
            rf_wr_reg  = wb_reg;
            rf_wr_data = wb_data;
          end else if (dbg_wr_valid) begin
            dbg_wr_ready = 1'b1;
            rf_wr_en     = 1'b1;
            rf_wr_reg    = dbg_wr_reg;
            rf_wr_data   = dbg_wr_data;
            wb_stall     = wb_valid;
          end
          // Starvation counter saturates; it only matters while debug is waiting.
          if (!dbg_wr_valid || dbg_wr_ready)
            starve_nxt = '0;
          else if (starve_cnt != SW'(STARVE))
            starve_nxt = starve_cnt + 1'b1;
          if (clear_req) begin
            state_nxt   = INIT;
            clr_cnt_nxt = '0;
            starve_nxt  = '0;
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  assign rf_rd_reg1 = rd_reg1;
  assign rf_rd_reg2 = rd_reg2;

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rf_rd_en1)
      rd_data1 = (rf_wr_en && rf_wr_reg == rd_reg1) ? rf_wr_data : rf_rd_data1;
    if (rf_rd_en2)
      rd_data2 = (rf_wr_en && rf_wr_reg == rd_reg2) ? rf_wr_data : rf_rd_data2;
  end

endmodule
